// File: rtl/axis_packetizer.sv
// AXI4-Stream packetizer: forwards beats unchanged and asserts tlast on every
// (cfg_data+1)-th accepted beat; output fully registered behind a 2-entry skid buffer.
module axis_packetizer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16,
  parameter int STS_WIDTH        = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  output logic [STS_WIDTH-1:0]        sts_data,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);
  localparam logic [STS_WIDTH-1:0]  STS_ONE = STS_WIDTH'(1);

  logic [CNTR_WIDTH-1:0]       cnt_reg;
  logic [CNTR_WIDTH-1:0]       len_reg;
  logic [STS_WIDTH-1:0]        sts_reg;
  logic                        ready_reg;
  logic [AXIS_TDATA_WIDTH-1:0] out_data_reg;
  logic                        out_last_reg;
  logic                        out_valid_reg;
  logic [AXIS_TDATA_WIDTH-1:0] skid_data_reg;
  logic                        skid_last_reg;
  logic                        skid_valid_reg;

  logic                  accept;
  logic                  out_hs;
  logic [CNTR_WIDTH-1:0] eff_len;
  logic                  beat_last;

  assign accept = s_axis_tvalid & ready_reg;
  assign out_hs = out_valid_reg & m_axis_tready;
  // A packet's first beat must use the live cfg_data; len_reg is only valid afterwards.
  assign eff_len   = (cnt_reg == '0) ? cfg_data : len_reg;
  assign beat_last = (cnt_reg == eff_len);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_reg        <= '0;
      len_reg        <= '0;
      sts_reg        <= '0;
      ready_reg      <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_last_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        if (cnt_reg == '0) len_reg <= cfg_data;
        cnt_reg <= beat_last ? '0 : cnt_reg + CNT_ONE;
      end

      if (out_hs && out_last_reg) sts_reg <= sts_reg + STS_ONE;

      if (!skid_valid_reg) ready_reg <= 1'b1;

      // Skid full implies ready_reg=0, so no accept can coincide with a skid drain.
      if (out_hs && skid_valid_reg) begin
        out_data_reg   <= skid_data_reg;
        out_last_reg   <= skid_last_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
        ready_reg      <= 1'b1;
      end else if (accept && (!out_valid_reg || out_hs)) begin
        out_data_reg  <= s_axis_tdata;
        out_last_reg  <= beat_last;
        out_valid_reg <= 1'b1;
      end else if (accept) begin
        skid_data_reg  <= s_axis_tdata;
        skid_last_reg  <= beat_last;
        skid_valid_reg <= 1'b1;
        ready_reg      <= 1'b0;
      end else if (out_hs) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign s_axis_tready = ready_reg;
  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tlast  = out_last_reg;
  assign m_axis_tvalid = out_valid_reg;
  assign sts_data      = sts_reg;

endmodule

// File: tb/tb_axis_packetizer.sv
// Randomized bench for axis_packetizer: a packet-level reference model predicts every
// delivered beat and its tlast; observed handshakes are compared against it.
module tb_axis_packetizer;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int SW = 32;

  typedef logic [DW:0] beat_t;  // {last, data}

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [CW-1:0] cfg_data;
  logic [SW-1:0] sts_data;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;

  axis_packetizer #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW), .STS_WIDTH(SW)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg_data), .sts_data(sts_data),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  int m_idx, m_len;
  bit seq_mode;
  logic [DW-1:0] seq_next;
  bit prev_stall, prev_rdy, prev_skid_cause, prev_last;
  logic [DW-1:0] prev_data;
  int stall_viol, ready_viol, ready_drops;

  task automatic clear_model();
    exp_q.delete(); got_q.delete();
    m_idx = 0; m_len = 0;
    prev_stall = 0; prev_rdy = 0; prev_skid_cause = 0;
    stall_viol = 0; ready_viol = 0; ready_drops = 0;
  endtask

  // One clock: observe handshakes just before the edge, update the model, then advance.
  task automatic tick();
    bit acc, hs, last;
    acc = aresetn && s_axis_tvalid && s_axis_tready;
    hs  = aresetn && m_axis_tvalid && m_axis_tready;
    if (aresetn) begin
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
        stall_viol++;
      if (prev_rdy && !s_axis_tready && !prev_skid_cause) ready_viol++;
      if (prev_rdy && !s_axis_tready) ready_drops++;
    end
    if (hs) got_q.push_back({m_axis_tlast, m_axis_tdata});
    if (acc) begin
      if (m_idx == 0) m_len = int'(cfg_data) + 1;
      last  = (m_idx == m_len - 1);
      m_idx = last ? 0 : m_idx + 1;
      exp_q.push_back({last, s_axis_tdata});
    end
    prev_stall      = aresetn && m_axis_tvalid && !m_axis_tready;
    prev_data       = m_axis_tdata;
    prev_last       = m_axis_tlast;
    prev_rdy        = aresetn && s_axis_tready;
    prev_skid_cause = acc && m_axis_tvalid && !m_axis_tready;
    @(posedge aclk);
    @(negedge aclk);
    if (acc) begin
      s_axis_tdata = seq_mode ? seq_next : $urandom();
      seq_next++;
    end
  endtask

  task automatic do_reset(input bit seq);
    aresetn = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    tick();
    aresetn = 1'b1;
    clear_model();
    seq_mode = seq; seq_next = 1;
    s_axis_tdata = seq ? '0 : $urandom();
    tick();
  endtask

  task automatic drain();
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    for (int i = 0; i < 64 && got_q.size() < exp_q.size(); i++) tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1; cfg_data = '0;
    tick();
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, s_axis_tready} !== 3'b000 || m_axis_tdata !== '0 || sts_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b last=%0b ready=%0b data=%h sts=%0d, want all 0",
               m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tdata, sts_data);
    end
    aresetn = 1'b1;
    tick();
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %0b want 1", s_axis_tready);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    cfg_data = 4'd3;
    do_reset(1);
    for (int i = 0; i < 13; i++) begin
      s_axis_tvalid = (i < 12); m_axis_tready = 1'b1;
      tick();
      if (i == 0) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd0) begin
          errors++; $display("FAIL basic_latency: got valid=%0b data=%0d want valid=1 data=0", m_axis_tvalid, m_axis_tdata);
        end
      end
    end
    checks++;
    if (got_q.size() != 12) begin errors++; $display("FAIL basic_throughput: got %0d beats want 12", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_q[i][DW] !== (i % 4 == 3) || got_q[i][DW-1:0] !== DW'(i)) begin
        errors++; $display("FAIL basic_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (sts_data !== 32'd3) begin errors++; $display("FAIL basic_sts: got %0d want 3", sts_data); end
    $display("test_basic done: %0d beats", got_q.size());
  endtask

  task automatic test_every_last();
    cfg_data = 4'd0;
    do_reset(0);
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() < 5; i++) tick();
    drain();
    checks++;
    if (got_q.size() != 5) begin errors++; $display("FAIL every_last_count: got %0d want 5", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_q[i][DW] !== 1'b1) begin
        errors++; $display("FAIL every_last_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (sts_data !== 32'd5) begin errors++; $display("FAIL every_last_sts: got %0d want 5", sts_data); end
    $display("test_every_last done: %0d beats", got_q.size());
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int nl = 0;
    cfg_data = 4'd3;
    do_reset(0);
    for (int c = 0; c < 400 && exp_q.size() < 40; c++) begin
      s_axis_tvalid = 1'($urandom_range(0, 1));
      m_axis_tready = pat[c % 4];
      tick();
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size() || exp_q.size() != 40) begin
      errors++; $display("FAIL bp_count: got %0d beats want %0d (accepted)", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (exp_q[i][DW]) nl++;
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol); end
    checks++;
    if (ready_viol != 0) begin errors++; $display("FAIL bp_ready_drop: got %0d unexplained drops want 0", ready_viol); end
    checks++;
    if (ready_drops == 0) begin errors++; $display("FAIL bp_skid_used: got 0 ready drops want >0"); end
    checks++;
    if (sts_data !== SW'(nl)) begin errors++; $display("FAIL bp_sts: got %0d want %0d", sts_data, nl); end
    $display("test_backpressure done: %0d beats, %0d skid fills", got_q.size(), ready_drops);
  endtask

  task automatic test_cfg_change();
    logic [7:0] mask = 8'b1010_1000;
    cfg_data = 4'd3;
    do_reset(0);
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() < 8; i++) begin
      tick();
      if (exp_q.size() == 3) cfg_data = 4'd1;
    end
    drain();
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_q[i][DW] !== mask[i]) begin
        errors++; $display("FAIL cfg_change_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (sts_data !== 32'd3) begin errors++; $display("FAIL cfg_change_sts: got %0d want 3", sts_data); end
    $display("test_cfg_change done: %0d beats", got_q.size());
  endtask

  task automatic test_reset_mid_packet();
    cfg_data = 4'd7;
    do_reset(0);
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() < 8; i++) tick();
    drain();
    checks++;
    if (sts_data !== 32'd1) begin errors++; $display("FAIL mid_pre_sts: got %0d want 1", sts_data); end
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() < 13; i++) tick();
    m_axis_tready = 1'b0;
    tick(); tick();
    checks++;
    if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL mid_stalled: got valid=%0b ready=%0b want valid=1 ready=0", m_axis_tvalid, s_axis_tready);
    end
    aresetn = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    tick();
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, s_axis_tready} !== 3'b000 || m_axis_tdata !== '0 || sts_data !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: got valid=%0b last=%0b ready=%0b data=%h sts=%0d want all 0",
               m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tdata, sts_data);
    end
    aresetn = 1'b1;
    clear_model();
    tick();
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() < 8; i++) tick();
    drain();
    checks++;
    if (got_q.size() != 8) begin errors++; $display("FAIL mid_post_count: got %0d want 8", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_q[i][DW] !== (i == 7)) begin
        errors++; $display("FAIL mid_post_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (sts_data !== 32'd1) begin errors++; $display("FAIL mid_post_sts: got %0d want 1", sts_data); end
    $display("test_reset_mid_packet done: %0d beats after reset", got_q.size());
  endtask

  task automatic test_wrap();
    cfg_data = 4'd15;
    do_reset(0);
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < 80 && exp_q.size() < 32; i++) tick();
    drain();
    checks++;
    if (got_q.size() != 32) begin errors++; $display("FAIL wrap_count: got %0d want 32", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_q[i][DW] !== (i == 15 || i == 31)) begin
        errors++; $display("FAIL wrap_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (sts_data !== 32'd2) begin errors++; $display("FAIL wrap_sts: got %0d want 2", sts_data); end
    $display("test_wrap done: %0d beats", got_q.size());
  endtask

  initial begin
    aresetn = 1'b0; cfg_data = '0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    seq_mode = 0; seq_next = 0; prev_data = '0;
    clear_model();
    @(negedge aclk);
    test_reset();
    test_basic();
    test_every_last();
    test_backpressure();
    test_cfg_change();
    test_reset_mid_packet();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
